// File: rtl/tdm_demux2.sv
// Receive-side splitter for a two-slot TDM stream: rebuilds A/B sample pairs,
// tracks frame alignment and counts sync errors.
module tdm_demux2 #(
    parameter int WIDTH      = 8,
    parameter int LOCK_PAIRS = 2,
    parameter int GAP_MAX    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VALID,
    input  logic             SOF,
    output logic [WIDTH-1:0] OUT_A,
    output logic [WIDTH-1:0] OUT_B,
    output logic             PAIR_VALID,
    output logic             LOCKED,
    output logic             SYNC_ERR,
    output logic [7:0]       ERR_CNT
);

    typedef enum logic [1:0] {
        HUNT,
        EXP_B,
        EXP_A
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_PAIRS);
    localparam logic [7:0] GAP_N  = 8'(GAP_MAX);

    state_t           state;
    logic [3:0]       good_cnt;
    logic [7:0]       gap_cnt;
    logic [WIDTH-1:0] held_a;
    logic             err_event;

    // Duplicate A, orphan B after a pair, or an A left waiting too long for its B.
    always_comb begin
        err_event = 1'b0;
        if (IN_VALID) begin
            err_event = (state == EXP_B && SOF) || (state == EXP_A && !SOF);
        end else begin
            err_event = (state == EXP_B) && (gap_cnt == GAP_N - 8'd1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= HUNT;
            good_cnt   <= '0;
            gap_cnt    <= '0;
            held_a     <= '0;
            OUT_A      <= '0;
            OUT_B      <= '0;
            PAIR_VALID <= 1'b0;
            LOCKED     <= 1'b0;
            SYNC_ERR   <= 1'b0;
            ERR_CNT    <= '0;
        end else begin
            PAIR_VALID <= 1'b0;
            SYNC_ERR   <= 1'b0;

            case (state)
                HUNT: begin
                    if (IN_VALID && SOF) begin
                        held_a  <= IN;
                        gap_cnt <= '0;
                        state   <= EXP_B;
                    end
                end
                EXP_B: begin
                    if (IN_VALID) begin
                        if (SOF) begin
                            held_a  <= IN;
                            gap_cnt <= '0;
                        end else begin
                            OUT_A      <= held_a;
                            OUT_B      <= IN;
                            PAIR_VALID <= 1'b1;
                            if (good_cnt < LOCK_N) begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                            if (good_cnt + 4'd1 >= LOCK_N) begin
                                LOCKED <= 1'b1;
                            end
                            state <= EXP_A;
                        end
                    end else if (gap_cnt == GAP_N - 8'd1) begin
                        gap_cnt <= '0;
                        state   <= HUNT;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                    end
                end
                EXP_A: begin
                    if (IN_VALID) begin
                        if (SOF) begin
                            held_a  <= IN;
                            gap_cnt <= '0;
                            state   <= EXP_B;
                        end else begin
                            state <= HUNT;
                        end
                    end
                end
                default: state <= HUNT;
            endcase

            // Any error breaks alignment; these assignments win over the pair path above.
            if (err_event) begin
                SYNC_ERR <= 1'b1;
                good_cnt <= '0;
                LOCKED   <= 1'b0;
                if (ERR_CNT != 8'hFF) begin
                    ERR_CNT <= ERR_CNT + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tdm_demux2.sv
// Bench for tdm_demux2: directed vector table, hand-written corner sequences,
// then random traffic compared against a pair-level reference model.
module tb_tdm_demux2;

    localparam int WIDTH      = 8;
    localparam int LOCK_PAIRS = 2;
    localparam int GAP_MAX    = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             in_valid;
    logic             sof;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             pair_valid;
    logic             locked;
    logic             sync_err;
    logic [7:0]       err_cnt;

    int checks = 0;
    int passes = 0;

    tdm_demux2 #(
        .WIDTH(WIDTH),
        .LOCK_PAIRS(LOCK_PAIRS),
        .GAP_MAX(GAP_MAX)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .IN(data_in),
        .IN_VALID(in_valid),
        .SOF(sof),
        .OUT_A(out_a),
        .OUT_B(out_b),
        .PAIR_VALID(pair_valid),
        .LOCKED(locked),
        .SYNC_ERR(sync_err),
        .ERR_CNT(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       valid;
        bit       sof;
        bit [7:0] data;
        bit       pv;
        bit [7:0] oa;
        bit [7:0] ob;
        bit       lk;
        bit       er;
        bit [7:0] cnt;
    } vec_t;

    vec_t vecs[11];

    // Reference model: a pending A sample, whether the stream just finished a pair,
    // the run of good pairs, and idle cycles spent waiting for B.
    bit       m_pending;
    bit [7:0] m_held;
    bit       m_after_pair;
    int       m_run;
    int       m_idle;
    bit [7:0] m_oa, m_ob;
    bit       m_pv, m_lk, m_er;
    int       m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic applyStimulus(input bit v, input bit s, input bit [7:0] d);
        in_valid = v;
        sof      = s;
        data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset(input bit v, input bit s, input bit [7:0] d);
        rst      = 1'b1;
        in_valid = v;
        sof      = s;
        data_in  = d;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic modelReset();
        m_pending = 0; m_held = 0; m_after_pair = 0; m_run = 0; m_idle = 0;
        m_oa = 0; m_ob = 0; m_pv = 0; m_lk = 0; m_er = 0; m_cnt = 0;
    endtask

    task automatic modelError();
        m_er  = 1;
        m_run = 0;
        m_lk  = 0;
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
    endtask

    task automatic modelStep(input bit v, input bit s, input bit [7:0] d);
        m_pv = 0;
        m_er = 0;
        if (v && s) begin
            if (m_pending) modelError();
            m_pending = 1;
            m_held    = d;
            m_idle    = 0;
        end else if (v) begin
            if (m_pending) begin
                m_oa = m_held;
                m_ob = d;
                m_pv = 1;
                m_run = (m_run + 1 > LOCK_PAIRS) ? LOCK_PAIRS : m_run + 1;
                if (m_run == LOCK_PAIRS) m_lk = 1;
                m_pending    = 0;
                m_after_pair = 1;
            end else if (m_after_pair) begin
                modelError();
                m_after_pair = 0;
            end
        end else if (m_pending) begin
            m_idle++;
            if (m_idle == GAP_MAX) begin
                modelError();
                m_pending    = 0;
                m_after_pair = 0;
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        check({tag, "_pv"},  32'(pair_valid), 32'(m_pv));
        check({tag, "_oa"},  32'(out_a), 32'(m_oa));
        check({tag, "_ob"},  32'(out_b), 32'(m_ob));
        check({tag, "_lk"},  32'(locked), 32'(m_lk));
        check({tag, "_err"}, 32'(sync_err), 32'(m_er));
        check({tag, "_cnt"}, 32'(err_cnt), 32'(m_cnt));
        check({tag, "_excl"}, 32'(pair_valid & sync_err), 32'd0);
    endtask

    task automatic randStep(input bit v, input bit s, input bit [7:0] d);
        applyStimulus(v, s, d);
        modelStep(v, s, d);
        checkOutput("rand");
    endtask

    initial begin
        int exp_cnt;

        vecs[0]  = '{1, 1, 8'h11, 0, 8'h00, 8'h00, 0, 0, 8'd0};
        vecs[1]  = '{1, 0, 8'h22, 1, 8'h11, 8'h22, 0, 0, 8'd0};
        vecs[2]  = '{1, 1, 8'h33, 0, 8'h11, 8'h22, 0, 0, 8'd0};
        vecs[3]  = '{1, 0, 8'h44, 1, 8'h33, 8'h44, 1, 0, 8'd0};
        vecs[4]  = '{1, 1, 8'h55, 0, 8'h33, 8'h44, 1, 0, 8'd0};
        vecs[5]  = '{1, 1, 8'h66, 0, 8'h33, 8'h44, 0, 1, 8'd1};
        vecs[6]  = '{1, 0, 8'h77, 1, 8'h66, 8'h77, 0, 0, 8'd1};
        vecs[7]  = '{1, 1, 8'h88, 0, 8'h66, 8'h77, 0, 0, 8'd1};
        vecs[8]  = '{1, 0, 8'h89, 1, 8'h88, 8'h89, 1, 0, 8'd1};
        vecs[9]  = '{1, 0, 8'h99, 0, 8'h88, 8'h89, 0, 1, 8'd2};
        vecs[10] = '{1, 0, 8'hAA, 0, 8'h88, 8'h89, 0, 0, 8'd2};

        rst = 1'b0; in_valid = 1'b0; sof = 1'b0; data_in = '0;
        @(posedge clk);
        #1;
        pulseReset(1'b1, 1'b1, 8'hEE);
        check("reset_oa",  32'(out_a), 32'd0);
        check("reset_ob",  32'(out_b), 32'd0);
        check("reset_pv",  32'(pair_valid), 32'd0);
        check("reset_lk",  32'(locked), 32'd0);
        check("reset_err", 32'(sync_err), 32'd0);
        check("reset_cnt", 32'(err_cnt), 32'd0);

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].sof, vecs[i].data);
            check($sformatf("vec%0d_pv", i),  32'(pair_valid), 32'(vecs[i].pv));
            check($sformatf("vec%0d_oa", i),  32'(out_a), 32'(vecs[i].oa));
            check($sformatf("vec%0d_ob", i),  32'(out_b), 32'(vecs[i].ob));
            check($sformatf("vec%0d_lk", i),  32'(locked), 32'(vecs[i].lk));
            check($sformatf("vec%0d_err", i), 32'(sync_err), 32'(vecs[i].er));
            check($sformatf("vec%0d_cnt", i), 32'(err_cnt), 32'(vecs[i].cnt));
        end

        // One idle cycle short of the timeout still completes the pair.
        applyStimulus(1, 1, 8'h12);
        for (int i = 0; i < GAP_MAX - 1; i++) applyStimulus(0, 0, 8'h00);
        check("gap15_err", 32'(sync_err), 32'd0);
        applyStimulus(1, 0, 8'h34);
        check("gap15_pv",  32'(pair_valid), 32'd1);
        check("gap15_oa",  32'(out_a), 32'h12);
        check("gap15_ob",  32'(out_b), 32'h34);
        check("gap15_cnt", 32'(err_cnt), 32'd2);

        applyStimulus(1, 1, 8'h56);
        for (int i = 0; i < GAP_MAX - 1; i++) applyStimulus(0, 0, 8'h00);
        check("gap16_early", 32'(sync_err), 32'd0);
        applyStimulus(0, 0, 8'h00);
        check("gap16_err", 32'(sync_err), 32'd1);
        check("gap16_cnt", 32'(err_cnt), 32'd3);
        check("gap16_lk",  32'(locked), 32'd0);
        applyStimulus(1, 0, 8'h34);
        check("gap16_nopair", 32'(pair_valid), 32'd0);
        check("gap16_noerr",  32'(sync_err), 32'd0);
        check("gap16_oa",     32'(out_a), 32'h12);

        exp_cnt = 3;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1, 1, 8'(i));
            applyStimulus(1, 0, 8'(i + 1));
            applyStimulus(1, 0, 8'(i + 2));
            exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
            check($sformatf("sat%0d_cnt", i), 32'(err_cnt), 32'(exp_cnt));
        end
        check("sat_final", 32'(err_cnt), 32'd255);

        // Reset between an A and its B discards the held A and the later B.
        applyStimulus(1, 1, 8'hF0);
        pulseReset(1, 0, 8'h0F);
        check("midrst_oa",  32'(out_a), 32'd0);
        check("midrst_ob",  32'(out_b), 32'd0);
        check("midrst_pv",  32'(pair_valid), 32'd0);
        check("midrst_lk",  32'(locked), 32'd0);
        check("midrst_err", 32'(sync_err), 32'd0);
        check("midrst_cnt", 32'(err_cnt), 32'd0);
        applyStimulus(1, 0, 8'h0F);
        check("midrst_b_pv",  32'(pair_valid), 32'd0);
        check("midrst_b_err", 32'(sync_err), 32'd0);
        check("midrst_b_ob",  32'(out_b), 32'd0);

        pulseReset(0, 0, 8'h00);
        modelReset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r == 0) begin
                pulseReset(1, 1, 8'($urandom));
                modelReset();
                checkOutput("rand_rst");
            end else if (r < 4) begin
                int len;
                len = int'($urandom_range(GAP_MAX - 3, GAP_MAX + 3));
                for (int k = 0; k < len; k++) randStep(0, 0, 8'($urandom));
            end else begin
                randStep($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 8'($urandom));
            end
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
